// File: rtl/glitch_sweep_pkg.sv
// Shared types and constants for the glitch parameter sweeper.
// GLITCH_SWEEP_REPEAT_EN (optional) enables per-point repeat attempts.
package glitch_sweep_pkg;

  localparam int SWEEP_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_RESET       = 3'd1,
    ST_ARM         = 3'd2,
    ST_WAIT_GLITCH = 3'd3,
    ST_SETTLE      = 3'd4,
    ST_ADVANCE     = 3'd5
  } sweep_state_t;

endpackage

// File: rtl/sweep_stepper.sv
// Combinational grid-axis stepper: next value and end-of-range detection.
// A zero step is promoted to 1; the sum is one bit wider so it can never wrap.
module sweep_stepper
  import glitch_sweep_pkg::*;
#(
  parameter int W = SWEEP_W
) (
  input  logic [W-1:0] cur,
  input  logic [W-1:0] last,
  input  logic [W-1:0] step,
  output logic [W-1:0] next,
  output logic         is_last
);

  logic [W-1:0] step_fix;
  logic [W:0]   sum;

  always_comb begin
    step_fix = step;
    if (step == '0) step_fix = {{(W-1){1'b0}}, 1'b1};
    sum     = {1'b0, cur} + {1'b0, step_fix};
    next    = sum[W-1:0];
    is_last = (cur >= last) || (sum > {1'b0, last}) || sum[W];
  end

endmodule

// File: rtl/glitch_sweeper.sv
// Voltage-glitch (offset, duration) grid sweeper; duration is the inner loop.
// GLITCH_SWEEP_REPEAT_EN adds repeat_count: each point is attempted N times.
//
// state       | meaning
// IDLE        | waiting for start, drive outputs low
// RESET       | target_reset held for RESET_CYCLES
// ARM         | offset counter enabled, first cycle
// WAIT_GLITCH | offset counter enabled until glitch_done
// SETTLE      | quiet for SETTLE_CYCLES
// ADVANCE     | step the grid (or repeat / finish)
module glitch_sweeper
  import glitch_sweep_pkg::*;
#(
  parameter int W             = SWEEP_W,
  parameter int RESET_CYCLES  = 1000,
  parameter int SETTLE_CYCLES = 100000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] offset_first,
  input  logic [W-1:0] offset_last,
  input  logic [W-1:0] offset_step,
  input  logic [W-1:0] duration_first,
  input  logic [W-1:0] duration_last,
  input  logic [W-1:0] duration_step,
`ifdef GLITCH_SWEEP_REPEAT_EN
  input  logic [15:0]  repeat_count,
`endif
  input  logic         glitch_done,
  output logic         target_reset,
  output logic         start_offset_counter,
  output logic [W-1:0] offset,
  output logic [W-1:0] duration,
  output logic         busy,
  output logic         attempt,
  output logic         sweep_done
);

  localparam logic [31:0] RESET_LOAD  = 32'(RESET_CYCLES - 1);
  localparam logic [31:0] SETTLE_LOAD = 32'(SETTLE_CYCLES - 1);

  sweep_state_t state, next_state;
  logic [31:0]  cnt;

  logic [W-1:0] lat_off_last, lat_off_step;
  logic [W-1:0] lat_dur_first, lat_dur_last, lat_dur_step;

  logic [W-1:0] off_next, dur_next;
  logic         off_is_last, dur_is_last;
  logic         repeat_more;
  logic         grid_end;
  logic         aborting;

  sweep_stepper #(.W(W)) u_off_step (
    .cur     (offset),
    .last    (lat_off_last),
    .step    (lat_off_step),
    .next    (off_next),
    .is_last (off_is_last)
  );

  sweep_stepper #(.W(W)) u_dur_step (
    .cur     (duration),
    .last    (lat_dur_last),
    .step    (lat_dur_step),
    .next    (dur_next),
    .is_last (dur_is_last)
  );

`ifdef GLITCH_SWEEP_REPEAT_EN
  logic [15:0] lat_rep_total;
  logic [15:0] rep_cnt;

  assign repeat_more = ({1'b0, rep_cnt} + 17'd1) < {1'b0, lat_rep_total};

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_rep_total <= '0;
      rep_cnt       <= '0;
    end else if (state == ST_IDLE && start) begin
      lat_rep_total <= (repeat_count == 16'd0) ? 16'd1 : repeat_count;
      rep_cnt       <= '0;
    end else if (state == ST_ADVANCE && !abort) begin
      rep_cnt <= repeat_more ? rep_cnt + 16'd1 : 16'd0;
    end else if (aborting) begin
      rep_cnt <= '0;
    end
  end
`else
  assign repeat_more = 1'b0;
`endif

  assign grid_end = !repeat_more && dur_is_last && off_is_last;
  assign aborting = abort && (state != ST_IDLE);

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:        if (start) next_state = ST_RESET;
      ST_RESET:       if (cnt == '0) next_state = ST_ARM;
      ST_ARM:         next_state = ST_WAIT_GLITCH;
      ST_WAIT_GLITCH: if (glitch_done) next_state = ST_SETTLE;
      ST_SETTLE:      if (cnt == '0) next_state = ST_ADVANCE;
      ST_ADVANCE:     next_state = grid_end ? ST_IDLE : ST_RESET;
      default:        next_state = ST_IDLE;
    endcase
    // abort outranks glitch_done and interval expiry
    if (aborting) next_state = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= ST_IDLE;
      cnt                  <= '0;
      target_reset         <= 1'b0;
      start_offset_counter <= 1'b0;
      busy                 <= 1'b0;
      attempt              <= 1'b0;
      sweep_done           <= 1'b0;
    end else begin
      state                <= next_state;
      target_reset         <= (next_state == ST_RESET);
      start_offset_counter <= (next_state == ST_ARM) || (next_state == ST_WAIT_GLITCH);
      busy                 <= (next_state != ST_IDLE);
      attempt              <= (next_state == ST_RESET) && (state != ST_RESET);
      sweep_done           <= (state == ST_ADVANCE) && !abort && grid_end;

      // one down-counter serves both the RESET and SETTLE intervals
      if (next_state == ST_RESET && state != ST_RESET)
        cnt <= RESET_LOAD;
      else if (next_state == ST_SETTLE && state != ST_SETTLE)
        cnt <= SETTLE_LOAD;
      else if (next_state == ST_IDLE)
        cnt <= '0;
      else if (cnt != '0)
        cnt <= cnt - 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_off_last  <= '0;
      lat_off_step  <= '0;
      lat_dur_first <= '0;
      lat_dur_last  <= '0;
      lat_dur_step  <= '0;
      offset        <= '0;
      duration      <= '0;
    end else if (state == ST_IDLE && start) begin
      lat_off_last  <= offset_last;
      lat_off_step  <= offset_step;
      lat_dur_first <= duration_first;
      lat_dur_last  <= duration_last;
      lat_dur_step  <= duration_step;
      offset        <= offset_first;
      duration      <= duration_first;
    end else if (aborting) begin
      offset   <= '0;
      duration <= '0;
    end else if (state == ST_ADVANCE && !repeat_more) begin
      if (!dur_is_last) begin
        duration <= dur_next;
      end else if (!off_is_last) begin
        duration <= lat_dur_first;
        offset   <= off_next;
      end
    end
  end

endmodule

// File: tb/tb_glitch_sweeper.sv
// Directed bench for glitch_sweeper with RESET_CYCLES=4, SETTLE_CYCLES=8.
// Define GLITCH_SWEEP_REPEAT_EN to also exercise the repeat feature.
module tb_glitch_sweeper;

  localparam int RC = 4;
  localparam int SC = 8;

  logic        clk = 1'b0;
  logic        rst, start, abort, glitch_done;
  logic [31:0] offset_first, offset_last, offset_step;
  logic [31:0] duration_first, duration_last, duration_step;
  logic        target_reset, start_offset_counter, busy, attempt, sweep_done;
  logic [31:0] offset, duration;
`ifdef GLITCH_SWEEP_REPEAT_EN
  logic [15:0] repeat_count = 16'd0;
`endif

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int att_seen = 0;
  int sd_seen  = 0;

  always #5 clk = ~clk;

  glitch_sweeper #(.W(32), .RESET_CYCLES(RC), .SETTLE_CYCLES(SC)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .start                (start),
    .abort                (abort),
    .offset_first         (offset_first),
    .offset_last          (offset_last),
    .offset_step          (offset_step),
    .duration_first       (duration_first),
    .duration_last        (duration_last),
    .duration_step        (duration_step),
`ifdef GLITCH_SWEEP_REPEAT_EN
    .repeat_count         (repeat_count),
`endif
    .glitch_done          (glitch_done),
    .target_reset         (target_reset),
    .start_offset_counter (start_offset_counter),
    .offset               (offset),
    .duration             (duration),
    .busy                 (busy),
    .attempt              (attempt),
    .sweep_done           (sweep_done)
  );

  // pulse counters sample pre-update values at the active edge
  always @(posedge clk) begin
    if (attempt) att_seen++;
    if (sweep_done) sd_seen++;
  end

  typedef struct packed {
    logic [31:0]      of, ol, os, df, dl, ds;
    int               n;
    logic [5:0][31:0] eo;
    logic [5:0][31:0] ed;
    logic             spur;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_ranges(input vec_t v);
    offset_first   = v.of;
    offset_last    = v.ol;
    offset_step    = v.os;
    duration_first = v.df;
    duration_last  = v.dl;
    duration_step  = v.ds;
  endtask

  task automatic wait_attempt(input string name);
    int k = 0;
    while (!attempt && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_attempt_seen"}, {31'd0, attempt}, 32'd1);
  endtask

  task automatic run_sweep(input vec_t v, input string name);
    int a0, s0, trc, stc;
    a0 = att_seen;
    s0 = sd_seen;
    set_ranges(v);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (v.spur) begin
      offset_first = 32'd999; offset_last = 32'd0; offset_step = 32'd1;
      duration_first = 32'd777; duration_last = 32'd0; duration_step = 32'd3;
    end
    for (int p = 0; p < v.n; p++) begin
      wait_attempt(name);
      chk({name, "_offset"}, offset, v.eo[p]);
      chk({name, "_duration"}, duration, v.ed[p]);
      trc = 0;
      while (target_reset && trc < 20) begin
        trc++;
        @(negedge clk);
      end
      chk({name, "_reset_len"}, 32'(trc), 32'(RC));
      chk({name, "_arm"}, {31'd0, start_offset_counter}, 32'd1);
      @(negedge clk);
      if (v.spur) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      glitch_done = 1'b1;
      @(negedge clk);
      glitch_done = 1'b0;
      chk({name, "_soc_low"}, {31'd0, start_offset_counter}, 32'd0);
      stc = 0;
      while (!attempt && !sweep_done && stc < 40) begin
        glitch_done = v.spur && (stc == 2);
        stc++;
        @(negedge clk);
      end
      glitch_done = 1'b0;
      chk({name, "_settle_len"}, 32'(stc), 32'(SC + 1));
    end
    chk({name, "_sweep_done"}, {31'd0, sweep_done}, 32'd1);
    @(negedge clk);
    chk({name, "_idle"}, {30'd0, busy, sweep_done}, 32'd0);
    chk({name, "_attempts"}, 32'(att_seen - a0), 32'(v.n));
    chk({name, "_done_count"}, 32'(sd_seen - s0), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; glitch_done = 1'b0;
    offset_first = 0; offset_last = 0; offset_step = 0;
    duration_first = 0; duration_last = 0; duration_step = 0;

    vecs[0] = '{of: 32'd10, ol: 32'd20, os: 32'd10, df: 32'd1, dl: 32'd2, ds: 32'd1, n: 4,
                eo: {32'd0, 32'd0, 32'd20, 32'd20, 32'd10, 32'd10},
                ed: {32'd0, 32'd0, 32'd2, 32'd1, 32'd2, 32'd1}, spur: 1'b0};
    vecs[1] = '{of: 32'hFFFF_FFF0, ol: 32'hFFFF_FFFF, os: 32'h20, df: 32'd7, dl: 32'd7, ds: 32'd1, n: 1,
                eo: {160'd0, 32'hFFFF_FFF0}, ed: {160'd0, 32'd7}, spur: 1'b0};
    vecs[2] = '{of: 32'd50, ol: 32'd40, os: 32'd1, df: 32'd3, dl: 32'd3, ds: 32'd1, n: 1,
                eo: {160'd0, 32'd50}, ed: {160'd0, 32'd3}, spur: 1'b0};
    vecs[3] = '{of: 32'd0, ol: 32'd0, os: 32'd1, df: 32'd5, dl: 32'd7, ds: 32'd0, n: 3,
                eo: {96'd0, 32'd0, 32'd0, 32'd0}, ed: {96'd0, 32'd7, 32'd6, 32'd5}, spur: 1'b0};
    vecs[4] = '{of: 32'd5, ol: 32'd7, os: 32'd0, df: 32'd9, dl: 32'd9, ds: 32'd4, n: 3,
                eo: {96'd0, 32'd7, 32'd6, 32'd5}, ed: {96'd0, 32'd9, 32'd9, 32'd9}, spur: 1'b0};
    vecs[5] = '{of: 32'd1, ol: 32'd1, os: 32'd1, df: 32'hFFFF_FFFE, dl: 32'hFFFF_FFFF, ds: 32'd1, n: 2,
                eo: {128'd0, 32'd1, 32'd1}, ed: {128'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE}, spur: 1'b0};
    vecs[6] = vecs[0];
    vecs[6].spur = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_target_reset", {31'd0, target_reset}, 32'd0);
    chk("rst_soc", {31'd0, start_offset_counter}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_attempt", {31'd0, attempt}, 32'd0);
    chk("rst_sweep_done", {31'd0, sweep_done}, 32'd0);
    chk("rst_offset", offset, 32'd0);
    chk("rst_duration", duration, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_sweep(vecs[i], $sformatf("vec%0d", i));

    // abort coincident with glitch_done in WAIT_GLITCH
    s0 = sd_seen;
    set_ranges(vecs[0]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_attempt("abort");
    for (int k = 0; k < 20 && !start_offset_counter; k++) @(negedge clk);
    @(negedge clk);
    chk("abort_in_wait", {31'd0, start_offset_counter}, 32'd1);
    glitch_done = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    glitch_done = 1'b0;
    abort = 1'b0;
    chk("abort_outputs", {27'd0, busy, target_reset, start_offset_counter, attempt, sweep_done}, 32'd0);
    chk("abort_offset", offset, 32'd0);
    chk("abort_duration", duration, 32'd0);
    repeat (14) @(negedge clk);
    chk("abort_no_done", 32'(sd_seen - s0), 32'd0);
    chk("abort_stays_idle", {31'd0, busy}, 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_attempt", {31'd0, attempt}, 32'd1);
    chk("restart_offset", offset, 32'd10);
    chk("restart_duration", duration, 32'd1);

    // synchronous reset while in RESET
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_target_reset", {31'd0, target_reset}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_offset", offset, 32'd0);
    @(negedge clk);

`ifdef GLITCH_SWEEP_REPEAT_EN
    repeat_count = 16'd3;
    begin
      vec_t rv;
      rv = '{of: 32'd10, ol: 32'd10, os: 32'd1, df: 32'd1, dl: 32'd2, ds: 32'd1, n: 6,
             eo: {32'd10, 32'd10, 32'd10, 32'd10, 32'd10, 32'd10},
             ed: {32'd2, 32'd2, 32'd2, 32'd1, 32'd1, 32'd1}, spur: 1'b0};
      run_sweep(rv, "repeat");
    end
    repeat_count = 16'd0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
